// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the two-client AXI4-Lite GPIO arbiter.
//   state_t      : sequencer states (also exported for debug).
//   RESP_*       : AXI response codes used by the block.
//   client_idx_t : index of a requesting client (0 or 1).
package gpio_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic client_idx_t;

endpackage

// File: rtl/gpio_axil_rr_arb.sv
// Two-way round-robin grant logic (purely combinational).
//   req_valid   : pending command per client.
//   last_grant  : client granted most recently.
//   enable      : arbitration allowed this cycle (sequencer idle).
//   grant_valid : a client is granted this cycle.
//   grant_idx   : granted client.
module gpio_axil_rr_arb
  import gpio_arb_pkg::*;
(
  input  logic        [1:0] req_valid,
  input  client_idx_t       last_grant,
  input  logic              enable,
  output logic              grant_valid,
  output client_idx_t       grant_idx
);

  always_comb begin
    grant_valid = enable && (req_valid != 2'b00);
    // On a tie the client that did not win last time goes next; otherwise
    // the single requester wins (value is ignored when nobody requests).
    if (req_valid == 2'b11) grant_idx = ~last_grant;
    else                    grant_idx = req_valid[1];
  end

endmodule

// File: rtl/gpio_axil_arbiter.sv
// Two-client AXI4-Lite master sharing the GPIO register port.
//   ACLK / ARESET           : clock, asynchronous active-high reset.
//   req_*                   : per-client command port (packed per client).
//   rsp_*                   : one-cycle completion pulse to the owning client.
//   m_axi_*                 : AXI4-Lite master toward the GPIO slave.
//   state_dbg               : current sequencer state.
// Handshake rule used everywhere: a transfer happens in a cycle where valid
// and ready are both high; a raised valid stays high (payload stable) until
// its own transfer, and is then dropped and never repeated.
module gpio_axil_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_write,
  input  logic [2*ADDR_WIDTH-1:0]       req_addr,
  input  logic [2*DATA_WIDTH-1:0]       req_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0]   req_wstrb,
  output logic [1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output state_t                        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  state, state_nxt;
  client_idx_t             last_grant, owner, grant_idx;
  logic                    grant_valid;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH/8-1:0] lat_wstrb;
  logic                    aw_done, w_done, aw_hs, w_hs;
  logic [CNT_W-1:0]        to_cnt;
  logic                    to_hit;
  logic [DATA_WIDTH-1:0]   cap_rdata;
  logic [1:0]              cap_resp;
  logic                    cap_timeout;

  gpio_axil_rr_arb u_arb (
    .req_valid   (req_valid),
    .last_grant  (last_grant),
    .enable      (state == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  // Abort after TIMEOUT response-phase cycles without the slave answering.
  assign to_hit = (to_cnt == CNT_W'(TIMEOUT - 1));

  assign m_axi_awaddr = lat_addr;
  assign m_axi_araddr = lat_addr;
  assign m_axi_wdata  = lat_wdata;
  assign m_axi_wstrb  = lat_wstrb;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign state_dbg    = state;

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (grant_valid)
                    state_nxt = req_write[grant_idx] ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (m_axi_bvalid || to_hit) state_nxt = ST_RESP;
      ST_RD_REQ:  if (m_axi_arready) state_nxt = ST_RD_RESP;
      ST_RD_RESP: if (m_axi_rvalid || to_hit) state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. Gated by ARESET so every output reads as its reset value
  // for the whole time reset is held, including the IDLE-only readies.
  always_comb begin
    req_ready     = 2'b00;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 2'b00;
    rsp_rdata     = '0;
    rsp_resp      = RESP_OKAY;
    rsp_timeout   = 1'b0;
    if (!ARESET) begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) req_ready[grant_idx] = 1'b1;
          // Soak up late B/R beats from an aborted transaction.
          m_axi_bready = 1'b1;
          m_axi_rready = 1'b1;
        end
        ST_WR_REQ: begin
          m_axi_awvalid = !aw_done;
          m_axi_wvalid  = !w_done;
        end
        ST_WR_RESP: m_axi_bready  = 1'b1;
        ST_RD_REQ:  m_axi_arvalid = 1'b1;
        ST_RD_RESP: m_axi_rready  = 1'b1;
        ST_RESP: begin
          rsp_valid[owner] = 1'b1;
          rsp_rdata        = cap_rdata;
          rsp_resp         = cap_resp;
          rsp_timeout      = cap_timeout;
        end
        default: ;
      endcase
    end
  end

  // Request latch, handshake tracking, timeout counter, response capture.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_wstrb   <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      to_cnt      <= '0;
      cap_rdata   <= '0;
      cap_resp    <= RESP_OKAY;
      cap_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (grant_valid) begin
          owner      <= grant_idx;
          last_grant <= grant_idx;
          lat_addr   <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          lat_wdata  <= req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          lat_wstrb  <= req_wstrb[int'(grant_idx)*(DATA_WIDTH/8) +: (DATA_WIDTH/8)];
          aw_done    <= 1'b0;
          w_done     <= 1'b0;
        end
        ST_WR_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          to_cnt <= '0;
        end
        ST_RD_REQ: to_cnt <= '0;
        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            cap_rdata   <= '0;
            cap_resp    <= m_axi_bresp;
            cap_timeout <= 1'b0;
          end else if (to_hit) begin
            cap_rdata   <= '0;
            cap_resp    <= RESP_SLVERR;
            cap_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        ST_RD_RESP: begin
          if (m_axi_rvalid) begin
            cap_rdata   <= m_axi_rdata;
            cap_resp    <= m_axi_rresp;
            cap_timeout <= 1'b0;
          end else if (to_hit) begin
            cap_rdata   <= '0;
            cap_resp    <= RESP_SLVERR;
            cap_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_axil_arbiter.sv
module tb_gpio_axil_arbiter;
  import gpio_arb_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = 4;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [1:0]      req_valid, req_ready, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_wstrb;
  logic [1:0]      rsp_valid, rsp_resp;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_timeout;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]      m_axi_awprot, m_axi_arprot;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic            m_axi_bvalid, m_axi_bready;
  logic            m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  state_t          state_dbg;

  gpio_axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .state_dbg(state_dbg)
  );

  // ---------------- GPIO slave model ----------------
  logic [DW-1:0] mem [4];
  int   aw_lat = 0, w_lat = 0;
  bit   b_hold = 0, r_hold = 0;
  int   aw_wait = 0, w_wait = 0;
  int   aw_hs_n = 0, w_hs_n = 0;
  logic have_aw = 0, have_w = 0, b_pend = 0, r_pend = 0;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] wd_q, merged;
  logic [SW-1:0] ws_q;
  logic aw_hs, w_hs, ar_hs, got_aw, got_w;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;

  always_comb begin
    m_axi_awready = m_axi_awvalid && (aw_wait >= aw_lat);
    m_axi_wready  = m_axi_wvalid && (w_wait >= w_lat);
    m_axi_arready = m_axi_arvalid;
    aw_hs   = m_axi_awvalid && m_axi_awready;
    w_hs    = m_axi_wvalid && m_axi_wready;
    ar_hs   = m_axi_arvalid && m_axi_arready;
    got_aw  = have_aw || aw_hs;
    got_w   = have_w || w_hs;
    wr_addr = have_aw ? aw_addr_q : m_axi_awaddr;
    wr_data = have_w ? wd_q : m_axi_wdata;
    wr_strb = have_w ? ws_q : m_axi_wstrb;
    merged  = '0;
    for (int b = 0; b < SW; b++)
      merged[8*b +: 8] = wr_strb[b] ? wr_data[8*b +: 8] : mem[wr_addr[3:2]][8*b +: 8];
  end

  always @(posedge ACLK) begin
    if (ARESET) begin
      have_aw <= 0; have_w <= 0; b_pend <= 0; r_pend <= 0;
      m_axi_bvalid <= 0; m_axi_rvalid <= 0; aw_wait <= 0; w_wait <= 0;
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      if (aw_hs) begin have_aw <= 1; aw_addr_q <= m_axi_awaddr; aw_hs_n <= aw_hs_n + 1; end
      if (w_hs)  begin have_w <= 1; wd_q <= m_axi_wdata; ws_q <= m_axi_wstrb; w_hs_n <= w_hs_n + 1; end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 0;
      if (got_aw && got_w) begin
        have_aw <= 0; have_w <= 0;
        if (wr_addr == 4'hC) m_axi_bresp <= RESP_SLVERR;
        else begin mem[wr_addr[3:2]] <= merged; m_axi_bresp <= RESP_OKAY; end
        if (b_hold) b_pend <= 1; else m_axi_bvalid <= 1;
      end
      if (b_pend && !b_hold) begin m_axi_bvalid <= 1; b_pend <= 0; end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 0;
      if (ar_hs) begin
        m_axi_rdata <= mem[m_axi_araddr[3:2]];
        m_axi_rresp <= RESP_OKAY;
        if (r_hold) r_pend <= 1; else m_axi_rvalid <= 1;
      end
      if (r_pend && !r_hold) begin m_axi_rvalid <= 1; r_pend <= 0; end
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  typedef struct {
    logic [1:0]    who;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          to;
    int            c;
  } rsp_t;

  int   grant_idx_q[$];
  int   grant_cyc_q[$];
  rsp_t rsp_q[$];
  int   aw_vld_n = 0, w_vld_n = 0;

  always @(negedge ACLK) begin
    if (!ARESET) begin
      for (int i = 0; i < 2; i++)
        if (req_ready[i]) begin grant_idx_q.push_back(i); grant_cyc_q.push_back(cyc); end
      if (rsp_valid != 2'b00)
        rsp_q.push_back('{rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cyc});
      if (m_axi_awvalid) aw_vld_n <= aw_vld_n + 1;
      if (m_axi_wvalid)  w_vld_n  <= w_vld_n + 1;
    end
  end

  // ---------------- scoreboard / checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // Raise a command for client idx, hold it until accepted, then drop it.
  task automatic issue(input int idx, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    int n;
    req_write[idx]          = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wd;
    req_wstrb[idx*SW +: SW] = ws;
    req_valid[idx]          = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!req_ready[idx] && n < 100) begin @(negedge ACLK); n++; end
    check($sformatf("grant_wait_c%0d", idx), req_ready[idx], 1'b1);
    @(posedge ACLK); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_q.size() < target && n < 200) begin @(posedge ACLK); n++; end
    #1;
    check("rsp_arrived", rsp_q.size() >= target, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int gb, rb, awb, wb, awv, wv;
  int n;

  initial begin
    ARESET = 1'b1;
    req_valid = 2'b11; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    tick(2);

    // Reset state: everything quiet even with both clients requesting.
    check("rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                       m_axi_rready, req_ready, rsp_valid, rsp_timeout, rsp_resp}, '0);
    check("rst_rdata", rsp_rdata, '0);
    check("rst_addr", {m_axi_awaddr, m_axi_araddr, m_axi_awprot, m_axi_arprot}, '0);
    check("rst_state", state_dbg, ST_IDLE);
    req_valid = 2'b00;
    ARESET = 1'b0;
    tick(1);
    check("idle_readies", {m_axi_bready, m_axi_rready}, 2'b11);

    // Tie every round: client 0 writes, client 1 reads back; order 0,1,0,1.
    gb = grant_idx_q.size(); rb = rsp_q.size();
    fork
      begin
        issue(0, 1'b1, 4'h0, 32'h1111_1111, 4'hF);
        issue(0, 1'b1, 4'h8, 32'h3333_3333, 4'hF);
      end
      begin
        issue(1, 1'b0, 4'h0, '0, '0);
        issue(1, 1'b0, 4'h8, '0, '0);
      end
    join
    wait_rsp(rb + 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d", i), grant_idx_q[gb+i], i % 2);
      check($sformatf("rr_owner%0d", i), rsp_q[rb+i].who, (i % 2) ? 2'b10 : 2'b01);
    end
    check("rr_spacing", grant_cyc_q[gb+1] - grant_cyc_q[gb], 4);
    check("rr_rd0", rsp_q[rb+1].rdata, 32'h1111_1111);
    check("rr_rd8", rsp_q[rb+3].rdata, 32'h3333_3333);
    check("rr_wr_rdata", rsp_q[rb+0].rdata, '0);

    // Client 0 zero-wait write then read of 0x4.
    gb = grant_idx_q.size(); rb = rsp_q.size();
    issue(0, 1'b1, 4'h4, 32'h0000_0002, 4'hF);
    wait_rsp(rb + 1);
    check("wr_resp", rsp_q[rb].resp, RESP_OKAY);
    check("wr_to", rsp_q[rb].to, 1'b0);
    check("wr_owner", rsp_q[rb].who, 2'b01);
    check("wr_latency", rsp_q[rb].c - grant_cyc_q[gb], 3);
    check("wr_back_idle", state_dbg, ST_IDLE);
    gb = grant_idx_q.size(); rb = rsp_q.size();
    issue(0, 1'b0, 4'h4, '0, '0);
    wait_rsp(rb + 1);
    check("rd_data", rsp_q[rb].rdata, 32'h0000_0002);
    check("rd_resp", rsp_q[rb].resp, RESP_OKAY);
    check("rd_latency", rsp_q[rb].c - grant_cyc_q[gb], 3);

    // AW accepted three cycles before W; byte strobes applied.
    aw_lat = 0; w_lat = 3;
    gb = grant_idx_q.size(); rb = rsp_q.size();
    awb = aw_hs_n; wb = w_hs_n; awv = aw_vld_n; wv = w_vld_n;
    issue(0, 1'b1, 4'h8, 32'hDEAD_BEEF, 4'b0110);
    wait_rsp(rb + 1);
    check("split_aw_hs", aw_hs_n - awb, 1);
    check("split_w_hs", w_hs_n - wb, 1);
    check("split_aw_cycles", aw_vld_n - awv, 1);
    check("split_w_cycles", w_vld_n - wv, 4);
    check("split_latency", rsp_q[rb].c - grant_cyc_q[gb], 6);
    check("split_resp", rsp_q[rb].resp, RESP_OKAY);
    w_lat = 0;
    rb = rsp_q.size();
    issue(1, 1'b0, 4'h8, '0, '0);
    wait_rsp(rb + 1);
    check("strobe_merge", rsp_q[rb].rdata, 32'h33AD_BE33);

    // B withheld: abort after 8 waiting cycles, late B absorbed in IDLE.
    b_hold = 1;
    gb = grant_idx_q.size(); rb = rsp_q.size();
    issue(0, 1'b1, 4'h0, 32'h0000_0055, 4'hF);
    wait_rsp(rb + 1);
    check("to_latency", rsp_q[rb].c - grant_cyc_q[gb], 10);
    check("to_resp", rsp_q[rb].resp, RESP_SLVERR);
    check("to_flag", rsp_q[rb].to, 1'b1);
    check("to_rdata", rsp_q[rb].rdata, '0);
    check("to_owner", rsp_q[rb].who, 2'b01);
    b_hold = 0;
    tick(4);
    check("late_b_absorbed", m_axi_bvalid, 1'b0);
    check("late_b_no_rsp", rsp_q.size(), rb + 1);
    check("late_b_idle", state_dbg, ST_IDLE);
    rb = rsp_q.size();
    issue(0, 1'b0, 4'h0, '0, '0);
    wait_rsp(rb + 1);
    check("after_to_read", rsp_q[rb].rdata, 32'h0000_0055);
    check("after_to_flag", rsp_q[rb].to, 1'b0);

    // Reset while waiting for R.
    r_hold = 1;
    rb = rsp_q.size();
    issue(1, 1'b0, 4'h4, '0, '0);
    n = 0;
    while (state_dbg !== ST_RD_RESP && n < 20) begin tick(1); n++; end
    check("reach_rd_resp", state_dbg, ST_RD_RESP);
    #2 ARESET = 1'b1;
    #1;
    check("arst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                        m_axi_rready, req_ready, rsp_valid, rsp_timeout, rsp_resp}, '0);
    check("arst_addr", m_axi_araddr, '0);
    check("arst_state", state_dbg, ST_IDLE);
    tick(2);
    ARESET = 1'b0;
    r_hold = 0;
    tick(5);
    check("arst_no_rsp", rsp_q.size(), rb);
    gb = grant_idx_q.size();
    issue(1, 1'b0, 4'h4, '0, '0);
    wait_rsp(rb + 1);
    check("arst_next_data", rsp_q[rb].rdata, 32'h0000_0002);
    check("arst_next_owner", rsp_q[rb].who, 2'b10);
    check("arst_next_latency", rsp_q[rb].c - grant_cyc_q[gb], 3);

    // Slave error on 0xC.
    rb = rsp_q.size();
    issue(1, 1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF);
    wait_rsp(rb + 1);
    check("slverr_resp", rsp_q[rb].resp, RESP_SLVERR);
    check("slverr_to", rsp_q[rb].to, 1'b0);
    check("slverr_owner", rsp_q[rb].who, 2'b10);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_axil_arbiter.md
# gpio_axil_arbiter

Two-requester AXI4-Lite master that shares the GPIO peripheral's register port (4 × 32-bit registers, byte offsets 0x0–0xC) between two on-chip clients. Each client issues single read/write commands on a simple valid/ready request port. The block arbitrates round-robin, sequences exactly one AXI4-Lite transaction at a time, and returns the response to the owning client. It sits between the client logic and the GPIO slave, in place of a full AXI interconnect.

## Interface
Parameters:
- ADDR_WIDTH, 4, AXI byte-address width.
- DATA_WIDTH, 32, data width; DATA_WIDTH/8 strobe bits.
- TIMEOUT, 255, maximum cycles spent waiting in a response phase before abort; must be ≥1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - ACLK  in  1  clock.
  - ARESET  in  1  asynchronous, active-high reset.
- Client request port, index i ∈ {0,1}:
  - req_valid  in  2  command pending, per client.
  - req_ready  out  2  one-cycle acceptance pulse, per client.
  - req_write  in  2  1 = write, 0 = read.
  - req_addr  in  2×ADDR_WIDTH  packed; client i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
  - req_wdata  in  2×DATA_WIDTH  packed write data.
  - req_wstrb  in  2×DATA_WIDTH/8  packed strobes.
- Client response port:
  - rsp_valid  out  2  one-cycle completion pulse to the owner.
  - rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
  - rsp_resp  out  2  AXI response code, or 2'b10 on timeout.
  - rsp_timeout  out  1  set when the transaction was aborted by timeout.
- AXI4-Lite master:
  - m_axi_awaddr, m_axi_awprot (constant 3'b000), m_axi_awvalid, m_axi_awready.
  - m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready.
  - m_axi_bresp, m_axi_bvalid, m_axi_bready.
  - m_axi_araddr, m_axi_arprot (constant 3'b000), m_axi_arvalid, m_axi_arready.
  - m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rready.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP.
- IDLE, arbitration:
  - One req_valid asserted: that client is granted.
  - Both asserted: the client other than last_grant is granted.
  - On grant: pulse req_ready[g]; latch write, addr, wdata, wstrb and g; update last_grant.
  - Next state is WR_REQ for a write, RD_REQ for a read.
- WR_REQ:
  - awvalid and wvalid are asserted together.
  - Each drops independently after its own handshake; a handshake is never repeated.
  - Go to WR_RESP once both handshakes have completed, including when they complete in the same cycle.
- WR_RESP: bready=1. On bvalid, capture bresp and go to RESP.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and rresp, then go to RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle; rsp_rdata, rsp_resp and rsp_timeout are valid in that cycle.
  - Then return to IDLE.
- Timeout:
  - The counter clears on entry to WR_RESP or RD_RESP and increments each cycle without bvalid/rvalid.
  - At count == TIMEOUT: go to RESP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - Address/data phases never time out, so AXI valid signals are never withdrawn.
- Stray responses: bready and rready are also 1 in IDLE. A late B/R accepted in IDLE is discarded and never reported to a client.
- Client rule: a client holds its request stable while req_valid=1 and req_ready=0. A client may deassert req_valid before it is granted.

## Timing
- Reset values:
  - All AXI valid/ready outputs, req_ready, rsp_valid and rsp_timeout: 0.
  - rsp_rdata and rsp_resp: 0.
  - State = IDLE; last_grant = 1, so client 0 wins the first tie; timeout counter = 0.
- req_ready is combinational from the state and req_valid, asserted in the IDLE cycle of the grant.
- The AXI valid signals assert in the cycle after the grant.
- Zero-wait slave, write:
  - Cycle 0 grant, cycle 1 AW+W handshake, cycle 2 B handshake, cycle 3 rsp_valid, cycle 4 IDLE.
  - 5 cycles per transaction end to end.
- Read: same cycle pattern as the write.
- A new grant can occur in the cycle after RESP.
- ARESET mid-transaction:
  - All outputs return to their reset values immediately (asynchronous); the latched request is dropped.
  - No rsp_valid is issued for the dropped request.

## Structure
- Package gpio_arb_pkg:
  - state enum;
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - a client-index typedef.
- Sub-module gpio_axil_rr_arb: 2-way round-robin grant logic.
  - Inputs: req_valid[1:0], last_grant, enable (IDLE).
  - Outputs: grant_valid, grant_idx.
- The top level contains the FSM, request latch, timeout counter and AXI drive.

## Test plan
- Client 0 writes 0x00000002 to 0x4, then reads 0x4 from a zero-wait GPIO model.
  - The write returns rsp_resp=00 after 5 cycles.
  - The read returns rsp_rdata=0x00000002.
- Both clients request on the same cycle for 4 rounds:
  - Grant order is 0,1,0,1.
  - Each rsp_valid goes only to its owner.
- Slave asserts awready 3 cycles before wready:
  - awvalid drops after its own handshake; wvalid stays asserted until its handshake.
  - Exactly one AW and one W are issued.
- Slave withholds bvalid, TIMEOUT=8:
  - rsp_valid occurs 9 cycles after the end of WR_REQ, with rsp_resp=10 and rsp_timeout=1.
  - A late bvalid arriving in IDLE is absorbed silently.
- ARESET asserted during RD_RESP:
  - All outputs are 0 within the same cycle and no rsp_valid follows.
  - The next request after reset completes normally.
- Slave returns SLVERR to a write to 0xC: rsp_resp=10 and rsp_timeout=0.
